// File: rtl/memaccess.sv
// Memory-access stage: LD/LDI/ST/STI sequencer toward a data memory with ack handshake.
// Define MEMACCESS_TIMEOUT_EN to abort an access that sees no ack for 255 cycles.
module memaccess (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  M_Control,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_din,
  output logic        dmem_rd,
  output logic        dmem_wr,
  input  logic [15:0] dmem_dout,
  input  logic        dmem_ack,
  output logic [15:0] memout,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    IND,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  op;
  logic [15:0] addr;
  logic [15:0] data;
  logic [15:0] ptr;
  logic        expired;
  logic        waiting;

  // op[0] selects indirect addressing, op[1] selects store
  logic is_ind;
  logic is_st;
  assign is_ind  = op[0];
  assign is_st   = op[1];
  assign waiting = (state == IND) || (state == ACCESS);

`ifdef MEMACCESS_TIMEOUT_EN
  logic [7:0] wcnt;

  assign expired = waiting && !dmem_ack && (wcnt == 8'hFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (waiting && !dmem_ack && !expired) begin
      wcnt <= wcnt + 8'd1;
    end else begin
      wcnt <= '0;
    end
  end
`else
  assign expired = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op     <= '0;
      addr   <= '0;
      data   <= '0;
      ptr    <= '0;
      memout <= '0;
      done   <= 1'b0;
      wb_en  <= 1'b0;
`ifdef MEMACCESS_TIMEOUT_EN
      err    <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
`ifdef MEMACCESS_TIMEOUT_EN
      err   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            op    <= M_Control;
            addr  <= M_Addr;
            data  <= M_Data;
            state <= M_Control[0] ? IND : ACCESS;
          end
        end
        IND: begin
          if (dmem_ack) begin
            ptr   <= dmem_dout;
            state <= ACCESS;
          end else if (expired) begin
            state <= DONE;
            done  <= 1'b1;
`ifdef MEMACCESS_TIMEOUT_EN
            err   <= 1'b1;
`endif
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            if (!is_st) begin
              memout <= dmem_dout;
            end
            state <= DONE;
            done  <= 1'b1;
            wb_en <= !is_st;
          end else if (expired) begin
            state <= DONE;
            done  <= 1'b1;
`ifdef MEMACCESS_TIMEOUT_EN
            err   <= 1'b1;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory request is a pure decode of the current state
  always_comb begin
    dmem_rd   = 1'b0;
    dmem_wr   = 1'b0;
    dmem_addr = '0;
    dmem_din  = '0;
    unique case (state)
      IND: begin
        dmem_rd   = 1'b1;
        dmem_addr = addr;
      end
      ACCESS: begin
        dmem_addr = is_ind ? ptr : addr;
        if (is_st) begin
          dmem_wr  = 1'b1;
          dmem_din = data;
        end else begin
          dmem_rd = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_memaccess.sv
// Scoreboard bench for memaccess: a wait-state memory model plus done/request monitors.
// Define MEMACCESS_TIMEOUT_EN to also exercise the ack timeout.
module tb_memaccess;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  M_Control = '0;
  logic [15:0] M_Addr = '0;
  logic [15:0] M_Data = '0;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [15:0] dmem_dout = '0;
  logic        dmem_ack = 1'b0;
  logic [15:0] memout;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic        err;

  memaccess dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .M_Control(M_Control),
    .M_Addr(M_Addr),
    .M_Data(M_Data),
    .dmem_addr(dmem_addr),
    .dmem_din(dmem_din),
    .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr),
    .dmem_dout(dmem_dout),
    .dmem_ack(dmem_ack),
    .memout(memout),
    .busy(busy),
    .done(done),
    .wb_en(wb_en),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int waitn = 0;
  int cnt = 0;
  logic [15:0] mem [int];

  typedef struct {
    logic [15:0] mo;
    logic        wb;
    logic        er;
    int          dc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } req_t;

  exp_t eq[$];
  req_t rq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory model: acks after waitn stall cycles, checks each served request
  always @(negedge clk) begin
    req_t r;
    chk("rd_wr_excl", {31'd0, dmem_rd & dmem_wr}, 32'd0);
    if (dmem_rd || dmem_wr) begin
      if (cnt >= waitn) begin
        dmem_ack = 1'b1;
        dmem_dout = mem.exists(int'(dmem_addr)) ? mem[int'(dmem_addr)] : 16'h0;
        chk("req_expected", {31'd0, rq.size() != 0}, 32'd1);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          chk("req_wr", {31'd0, dmem_wr}, {31'd0, r.wr});
          chk("req_addr", {16'd0, dmem_addr}, {16'd0, r.a});
          chk("req_din", {16'd0, dmem_din}, {16'd0, r.wr ? r.d : 16'h0});
        end
        if (dmem_wr) mem[int'(dmem_addr)] = dmem_din;
        cnt = 0;
      end else begin
        dmem_ack = 1'b0;
        cnt++;
      end
    end else begin
      dmem_ack = 1'b0;
      cnt = 0;
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    exp_t e;
    if (wb_en && !done) chk("wb_en_solo", {31'd0, wb_en}, {31'd0, done});
    if (rst && done) begin
      chk("done_expected", {31'd0, eq.size() != 0}, 32'd1);
      if (eq.size() != 0) begin
        e = eq.pop_front();
        chk("memout", {16'd0, memout}, {16'd0, e.mo});
        chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb});
        chk("err", {31'd0, err}, {31'd0, e.er});
        chk("done_cycle", cyc, e.dc);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [15:0] a,
                       input logic [15:0] d, input int w,
                       input logic [15:0] mo, input logic [15:0] ptr,
                       input bit extra, input bit dead);
    int lat;
    bit ok;
    logic ind;
    ind = op[0];
    @(negedge clk);
    waitn = dead ? 100000 : w;
    M_Control = op;
    M_Addr = a;
    M_Data = d;
    start = 1'b1;
    lat = dead ? 257 : 2 + int'(ind) + w * (1 + int'(ind));
    eq.push_back('{mo, dead ? 1'b0 : !op[1], dead, cyc + lat});
    if (!dead) begin
      if (ind) rq.push_back('{1'b0, a, 16'h0});
      rq.push_back('{op[1], ind ? ptr : a, d});
    end
    @(negedge clk);
    if (extra) begin
      M_Control = 2'b11;
      M_Addr = 16'hDEAD;
      M_Data = 16'hBEEF;
      repeat (2) @(negedge clk);
    end
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 700 && !ok; i++) begin
      if (!busy && eq.size() == 0) ok = 1'b1;
      else @(negedge clk);
    end
    chk("finish_in_time", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    mem[16'h3000] = 16'h8001;
    mem[16'h3010] = 16'h4000;
    mem[16'h4000] = 16'h0000;
    mem[16'h3020] = 16'h5000;
    mem[16'hABCD] = 16'h7777;

    start = 1'b1;
    M_Addr = 16'h3000;
    M_Data = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rd", {31'd0, dmem_rd}, 32'd0);
    chk("rst_wr", {31'd0, dmem_wr}, 32'd0);
    chk("rst_addr", {16'd0, dmem_addr}, 32'd0);
    chk("rst_din", {16'd0, dmem_din}, 32'd0);
    chk("rst_memout", {16'd0, memout}, 32'd0);
    start = 1'b0;
    rst = 1'b1;

    issue(2'b00, 16'h3000, 16'h0000, 0, 16'h8001, 16'h0000, 0, 0);
    issue(2'b01, 16'h3010, 16'h0000, 0, 16'h0000, 16'h4000, 0, 0);
    issue(2'b11, 16'h3020, 16'h1234, 2, 16'h0000, 16'h5000, 0, 0);
    issue(2'b00, 16'h5000, 16'h0000, 1, 16'h1234, 16'h0000, 0, 0);
    issue(2'b10, 16'h3100, 16'hABCD, 0, 16'h1234, 16'h0000, 0, 0);
    issue(2'b00, 16'h3000, 16'h0000, 0, 16'h8001, 16'h0000, 1, 0);
    issue(2'b01, 16'h3100, 16'h0000, 1, 16'h7777, 16'hABCD, 0, 0);

    @(negedge clk);
    waitn = 50;
    M_Control = 2'b00;
    M_Addr = 16'h3000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_before_rst", {31'd0, dmem_rd}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_rd", {31'd0, dmem_rd}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_memout", {16'd0, memout}, 32'd0);
    chk("abort_addr", {16'd0, dmem_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    waitn = 0;
    issue(2'b00, 16'h3000, 16'h0000, 0, 16'h8001, 16'h0000, 0, 0);

`ifdef MEMACCESS_TIMEOUT_EN
    issue(2'b10, 16'h3200, 16'h5555, 0, 16'h8001, 16'h0000, 0, 1);
    waitn = 0;
    issue(2'b00, 16'h3000, 16'h0000, 0, 16'h8001, 16'h0000, 0, 0);
`endif

    repeat (3) @(negedge clk);
    chk("req_drained", rq.size(), 32'd0);
    chk("done_drained", eq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
